// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: op codes, instruction layout and FSM encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_PASS = 3'd2,
        OP_LSH = 3'd3,
        OP_RSH = 3'd4,
        OP_AND = 3'd5,
        OP_NOT = 3'd6,
        OP_OR = 3'd7
    } op_t;

    // Field order fixes the bit positions: op[15:13] imm[12] rd[11:10] rs1[9:8] imm8[7:0]
    typedef struct packed {
        op_t op;
        logic imm;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [7:0] imm8;
    } instr_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB = 2'd2
    } state_t;

endpackage

// File: rtl/seq_regfile.sv
// 4x8 register file: two asynchronous read ports, one synchronous write port, async clear.
module seq_regfile (
    input logic clock,
    input logic reset,
    input logic we,
    input logic [1:0] wa,
    input logic [7:0] wd,
    input logic [1:0] ra1,
    output logic [7:0] rd1,
    input logic [1:0] ra2,
    output logic [7:0] rd2
);

    logic [3:0][7:0] regs;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs <= '0;
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

endmodule

// File: rtl/alu_sequencer.sv
// Issues one instruction at a time to the external ALU and writes the result back.
module alu_sequencer
    import alu_pkg::*;
(
    input logic clock,
    input logic reset,
    input logic in_valid,
    input logic [15:0] in_instr,
    output logic in_ready,
    output logic [7:0] alu_r1,
    output logic [7:0] alu_r2,
    output logic [2:0] alu_op,
    input logic [7:0] alu_out,
    output logic res_valid,
    output logic [7:0] res_data,
    output logic [1:0] res_rd,
    output logic res_zero,
    input logic res_ready,
    output logic [7:0] instr_count
);

    state_t state, nxt;
    instr_t ins;
    logic accept, wb;
    logic [1:0] rd_q;
    logic [7:0] src1, src2, op1, op2;

    assign ins = instr_t'(in_instr);

    seq_regfile u_rf (
        .clock(clock),
        .reset(reset),
        .we(wb),
        .wa(rd_q),
        .wd(alu_out),
        .ra1(ins.rs1),
        .rd1(src1),
        .ra2(ins.imm8[1:0]),
        .rd2(src2)
    );

    // Load immediate feeds imm8 to both ports so the ALU's pass-r1 yields it.
    always_comb begin
        op1 = src1;
        op2 = src2;
        if (ins.imm) begin
            op2 = ins.imm8;
            if (ins.op == OP_PASS) op1 = ins.imm8;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        accept = 1'b0;
        wb = 1'b0;
        case (state)
            S_IDLE: if (in_valid) begin
                accept = 1'b1;
                nxt = S_EXEC;
            end
            S_EXEC: begin
                wb = 1'b1;
                nxt = S_WB;
            end
            S_WB: if (res_ready) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    assign in_ready = (state == S_IDLE);
    assign res_valid = (state == S_WB);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_r1 <= '0;
            alu_r2 <= '0;
            alu_op <= '0;
            rd_q <= '0;
            res_data <= '0;
            res_rd <= '0;
            res_zero <= 1'b1;
            instr_count <= '0;
        end else begin
            if (accept) begin
                alu_r1 <= op1;
                alu_r2 <= op2;
                alu_op <= ins.op;
                rd_q <= ins.rd;
            end
            if (wb) begin
                res_data <= alu_out;
                res_rd <= rd_q;
                res_zero <= (alu_out == 8'd0);
                instr_count <= instr_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU hooked to its operand outputs.
module tb_alu_sequencer;

    logic clock = 1'b0;
    logic reset;
    logic in_valid;
    logic [15:0] in_instr;
    logic in_ready;
    logic [7:0] alu_r1, alu_r2, alu_out;
    logic [2:0] alu_op;
    logic res_valid, res_zero, res_ready;
    logic [7:0] res_data, instr_count;
    logic [1:0] res_rd;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    alu_sequencer dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_instr(in_instr),
        .in_ready(in_ready),
        .alu_r1(alu_r1),
        .alu_r2(alu_r2),
        .alu_op(alu_op),
        .alu_out(alu_out),
        .res_valid(res_valid),
        .res_data(res_data),
        .res_rd(res_rd),
        .res_zero(res_zero),
        .res_ready(res_ready),
        .instr_count(instr_count)
    );

    // Reference ALU: shifts and not act on r1 by one position
    always_comb begin
        case (alu_op)
            3'd0: alu_out = alu_r1 + alu_r2;
            3'd1: alu_out = alu_r1 - alu_r2;
            3'd2: alu_out = alu_r1;
            3'd3: alu_out = alu_r1 << 1;
            3'd4: alu_out = alu_r1 >> 1;
            3'd5: alu_out = alu_r1 & alu_r2;
            3'd6: alu_out = ~alu_r1;
            default: alu_out = alu_r1 | alu_r2;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] li(input logic [1:0] rd, input logic [7:0] v);
        return {3'd2, 1'b1, rd, 2'd0, v};
    endfunction

    function automatic logic [15:0] rr(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, 1'b0, rd, rs1, 6'd0, rs2};
    endfunction

    // Offer an instruction at a falling edge and return just after the accepting edge.
    task automatic offer(input logic [15:0] ins);
        int w = 0;
        @(negedge clock);
        while (!in_ready && w < 20) begin
            @(negedge clock);
            w++;
        end
        if (!in_ready) chk("in_ready timeout", 0, 1);
        in_valid = 1'b1;
        in_instr = ins;
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    // Full instruction with res_ready=1: check result one edge after accept.
    task automatic run(input string tag, input logic [15:0] ins,
                       input logic [7:0] exp, input logic [1:0] rd);
        offer(ins);
        @(posedge clock);
        #1;
        chk({tag, " valid"}, res_valid, 1);
        chk({tag, " data"}, res_data, exp);
        chk({tag, " rd"}, res_rd, rd);
        chk({tag, " zero"}, res_zero, exp == 8'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic run_q(input logic [15:0] ins);
        offer(ins);
        @(posedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        in_valid = 1'b0;
        in_instr = '0;
        res_ready = 1'b1;
        reset = 1'b1;
        #12;
        chk("rst in_ready", in_ready, 1);
        chk("rst res_valid", res_valid, 0);
        chk("rst res_data", res_data, 0);
        chk("rst res_zero", res_zero, 1);
        chk("rst alu_r1", alu_r1, 0);
        chk("rst alu_op", alu_op, 0);
        chk("rst count", instr_count, 0);
        @(negedge clock);
        reset = 1'b0;

        run("li5", li(2'd0, 8'd5), 8'd5, 2'd0);
        run("li20", li(2'd1, 8'd20), 8'd20, 2'd1);
        offer(rr(3'd0, 2'd2, 2'd0, 2'd1));
        chk("add r1", alu_r1, 5);
        chk("add r2", alu_r2, 20);
        chk("add op", alu_op, 0);
        chk("add in_ready", in_ready, 0);
        @(posedge clock);
        #1;
        chk("add data", res_data, 25);
        chk("add rd", res_rd, 2);
        chk("add zero", res_zero, 0);
        chk("add count", instr_count, 3);
        @(posedge clock);
        #1;
        chk("idle again", in_ready, 1);

        run("li96", li(2'd0, 8'd96), 8'd96, 2'd0);
        run("li69", li(2'd1, 8'd69), 8'd69, 2'd1);
        run("sub", rr(3'd1, 2'd3, 2'd0, 2'd1), 8'd27, 2'd3);
        run("subwrap", rr(3'd1, 2'd3, 2'd1, 2'd0), 8'd229, 2'd3);
        run("addi", {3'd0, 1'b1, 2'd2, 2'd3, 8'd30}, 8'd3, 2'd2);

        run("li255", li(2'd0, 8'd255), 8'd255, 2'd0);
        run("lsh", rr(3'd3, 2'd1, 2'd0, 2'd0), 8'd254, 2'd1);
        run("rsh", rr(3'd4, 2'd2, 2'd0, 2'd0), 8'd127, 2'd2);
        run("liAA", li(2'd0, 8'hAA), 8'hAA, 2'd0);
        run("not", rr(3'd6, 2'd3, 2'd0, 2'd0), 8'h55, 2'd3);
        run("li8", li(2'd0, 8'd8), 8'd8, 2'd0);
        run("li7", li(2'd1, 8'd7), 8'd7, 2'd1);
        run("and", rr(3'd5, 2'd2, 2'd0, 2'd1), 8'd0, 2'd2);
        run("or", rr(3'd7, 2'd3, 2'd0, 2'd1), 8'd15, 2'd3);
        chk("count 17", instr_count, 17);

        // Backpressure: WB held, second instruction waits
        res_ready = 1'b0;
        offer(rr(3'd0, 2'd2, 2'd0, 2'd1));
        @(negedge clock);
        in_valid = 1'b1;
        in_instr = li(2'd3, 8'd77);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chk("bp valid", res_valid, 1);
            chk("bp data", res_data, 15);
            chk("bp rd", res_rd, 2);
            chk("bp in_ready", in_ready, 0);
        end
        @(negedge clock);
        res_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("bp release", in_ready, 1);
        @(posedge clock);
        #1 in_valid = 1'b0;
        chk("bp accepted", in_ready, 0);
        @(posedge clock);
        #1;
        chk("bp2 data", res_data, 77);
        chk("bp2 rd", res_rd, 3);
        chk("bp count", instr_count, 19);
        @(posedge clock);
        #1;

        // Reset during EXEC
        offer(rr(3'd0, 2'd2, 2'd0, 2'd1));
        reset = 1'b1;
        #1;
        chk("mid res_valid", res_valid, 0);
        chk("mid in_ready", in_ready, 1);
        chk("mid alu_r1", alu_r1, 0);
        chk("mid res_zero", res_zero, 1);
        chk("mid count", instr_count, 0);
        @(posedge clock);
        #1 chk("mid no pulse", res_valid, 0);
        @(negedge clock);
        reset = 1'b0;
        run("rf01", rr(3'd7, 2'd0, 2'd0, 2'd1), 8'd0, 2'd0);
        run("rf23", rr(3'd7, 2'd1, 2'd2, 2'd3), 8'd0, 2'd1);
        run("post li", li(2'd2, 8'd9), 8'd9, 2'd2);
        run("post add", rr(3'd0, 2'd3, 2'd2, 2'd2), 8'd18, 2'd3);
        chk("post count", instr_count, 4);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 255; i++) run_q(li(2'(i), 8'(i)));
        chk("count 255", instr_count, 255);
        run_q(li(2'd0, 8'd1));
        chk("count wrap", instr_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction-issuing front end for the 8-bit combinational ALU. It accepts 16-bit instructions over a valid/ready handshake and holds a 4×8-bit register file. For each instruction it drives the ALU operand and op inputs, captures the ALU result, writes it back, and presents it on a result handshake. The ALU sits outside this block; the sequencer is the initiator and the ALU is the responder.

## Interface
- No parameters. Widths are fixed: data 8, instruction 16, register index 2.
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  instruction offered
- in_instr  in  16  instruction word (format below)
- in_ready  out  1  sequencer can accept an instruction
- alu_r1  out  8  ALU operand 1
- alu_r2  out  8  ALU operand 2
- alu_op  out  3  ALU op: 0 add, 1 sub, 2 pass r1, 3 lshift, 4 rshift, 5 and, 6 not, 7 or
- alu_out  in  8  ALU result, combinational from alu_r1/alu_r2/alu_op
- res_valid  out  1  result available
- res_data  out  8  written-back value
- res_rd  out  2  destination register of res_data
- res_zero  out  1  res_data == 0
- res_ready  in  1  consumer accepts result
- instr_count  out  8  completed instructions, wraps 255→0

## Operation
- Instruction fields:
  - [15:13] op
  - [12] imm
  - [11:10] rd
  - [9:8] rs1
  - [7:0] imm8 when imm=1; otherwise [1:0] is rs2 and [7:2] are ignored.
- Operand selection:
  - imm=0: alu_r1=R[rs1], alu_r2=R[rs2].
  - imm=1, op≠2: alu_r1=R[rs1], alu_r2=imm8.
  - imm=1, op=2 (load immediate): alu_r1=imm8, alu_r2=imm8.
- All arithmetic is modulo 256. No carry or overflow outputs.
- FSM states: IDLE, EXEC, WB.
  - IDLE: in_ready=1. On in_valid, latch the instruction, register alu_r1/alu_r2/alu_op, and go to EXEC.
  - EXEC: in_ready=0. The ALU settles. At the end of the cycle, write alu_out into R[rd] and into the result register, increment instr_count, and go to WB.
  - WB: res_valid=1. res_data/res_rd/res_zero are stable. On res_ready, go to IDLE.
- in_valid in EXEC or WB is ignored. The producer must hold it until in_ready.
- alu_r1/alu_r2/alu_op hold their last values outside EXEC.
- Source reads in IDLE use the register file as of that cycle. Write-back always completes before the next accept, so there is no hazard.

## Timing
- Reset values:
  - state IDLE
  - in_ready=1
  - R[0..3]=0
  - alu_r1/alu_r2/alu_op=0
  - res_valid=0, res_data=0, res_rd=0, res_zero=1
  - instr_count=0
- Latency:
  - Instruction accepted at edge N.
  - ALU inputs valid from edge N, through the EXEC cycle.
  - Write-back at edge N+1.
  - res_valid high from edge N+1.
- Minimum interval: 3 cycles per instruction (accept, EXEC, WB with res_ready=1). in_ready reasserts at edge N+2.
- Backpressure: res_ready=0 holds WB indefinitely. res_data and res_rd must not change, and in_ready stays 0.
- in_ready depends only on state. The block has no combinational in→out path except through the external ALU.
- Reset mid-operation (EXEC or WB):
  - Return to IDLE immediately.
  - Drop the pending result.
  - res_valid goes to 0 asynchronously.
  - The register file and counter clear.

## Structure
- Shared package alu_pkg holds:
  - the op-code constants (ADD=0 … OR=7)
  - the instruction field positions
  - the FSM state encoding
- One natural sub-module: seq_regfile (4×8, two async read ports, one sync write port, async clear on reset).
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Load immediates 5→R0 and 20→R1, then add R2=R0+R1 → res_data=25, res_rd=2, res_zero=0, instr_count=3.
- Load 96→R0 and 69→R1, sub R3=R0−R1 → 27. Then sub R3=R1−R0 → 229 (wrap).
- Load 255→R0, lshift → 254, rshift → 127. Load 0xAA→R0, not → 0x55. Load 8→R0 and 7→R1, and → 0, res_zero=1; or → 15.
- Backpressure: hold res_ready=0 for 5 cycles with in_valid=1 → res_data stable, in_ready=0, second instruction accepted only after res_ready=1.
- Reset asserted during EXEC of add → outputs at reset values, R0–R3=0, no res_valid pulse. The next instruction after deassertion executes normally.
- Run 256 load instructions → instr_count wraps to 0.
